// File: rtl/cam_pkg.sv
// cam_pkg: shared types and constants for the cam sequencing controller.
//   - cam_op_e    : request opcodes as carried on req_op_i
//   - cam_state_e : controller FSM states
//   - cam_rsp_t   : registered response fields (sized for the widest supported config)
package cam_pkg;

  localparam int CAM_DEF_DATA_WIDTH = 32;
  localparam int CAM_DEF_ENTRIES    = 16;

  // Response struct fields are sized generously; the top slices them back
  // down to the configured id/index widths.
  localparam int CAM_MAX_ID_W  = 8;
  localparam int CAM_MAX_IDX_W = 16;

  typedef enum logic [1:0] {
    CAM_LOOKUP = 2'd0,
    CAM_INSERT = 2'd1,
    CAM_DELETE = 2'd2
  } cam_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_EVAL   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } cam_state_e;

  typedef struct packed {
    logic [CAM_MAX_ID_W-1:0]  id;
    logic                     hit;
    logic                     full;
    logic [CAM_MAX_IDX_W-1:0] index;
  } cam_rsp_t;

  // The reserved opcode 3 behaves as a lookup.
  function automatic cam_op_e cam_decode_op(input logic [1:0] raw);
    case (raw)
      2'd1:    return CAM_INSERT;
      2'd2:    return CAM_DELETE;
      default: return CAM_LOOKUP;
    endcase
  endfunction

endpackage

// File: rtl/cam_rr_arbiter.sv
// cam_rr_arbiter: combinational round-robin pick.
//   req_i   : request vector
//   ptr_i   : requester with highest priority this cycle
//   grant_o : one-hot grant (first valid requester at or after ptr_i)
//   id_o    : encoded grant
//   any_o   : at least one request valid
module cam_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    id_o,
  output logic               any_o
);

  always_comb begin
    int cand;
    grant_o = '0;
    id_o    = '0;
    any_o   = 1'b0;
    cand    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr_i) + i) % NUM_REQ;
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        id_o          = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/cam_ctrl.sv
// cam_ctrl: shares one cam between NUM_REQ requesters.
//   req_*_i / req_ready_o : per-requester lookup/insert/delete, one-hot accept pulse
//   rsp_*_o               : one-cycle response (fields zero when rsp_valid_o=0)
//   occupancy_o           : number of allocated entries
//   cam_search_* / cam_write_* : cam search and write ports (result one cycle after search)
// A valid bitmap decides entry visibility; deleted entries keep their cam
// contents, so a later insert of the same key re-allocates the stale slot
// instead of writing a duplicate.
//
// state  | meaning
// IDLE   | arbitrate and accept a request
// SEARCH | drive cam search with the latched key
// EVAL   | interpret cam hit/index against the bitmap
// WRITE  | write latched key into the chosen free entry
// RESP   | present the response for one cycle
module cam_ctrl
  import cam_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = CAM_DEF_DATA_WIDTH,
  parameter int ENTRIES    = CAM_DEF_ENTRIES,
  parameter int IDX_W      = $clog2(ENTRIES),
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [2*NUM_REQ-1:0]          req_op_i,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data_i,
  input  logic [IDX_W*NUM_REQ-1:0]      req_index_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          rsp_valid_o,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic                          rsp_hit_o,
  output logic                          rsp_full_o,
  output logic [IDX_W-1:0]              rsp_index_o,
  output logic [IDX_W:0]                occupancy_o,
  output logic                          cam_search_o,
  output logic [DATA_WIDTH-1:0]         cam_search_data_o,
  input  logic                          cam_search_valid_i,
  input  logic [IDX_W-1:0]              cam_search_index_i,
  output logic                          cam_write_o,
  output logic [IDX_W-1:0]              cam_write_index_o,
  output logic [DATA_WIDTH-1:0]         cam_write_data_o
);

  cam_state_e            state_q, state_d;
  cam_op_e               op_q, op_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ENTRIES-1:0]    bitmap_q, bitmap_d;
  logic [IDX_W:0]        occ_q, occ_d;
  cam_rsp_t              rsp_q, rsp_d;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;

  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               raw_hit;
  logic               eff_hit;
  logic               unused_rsp;

  cam_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (gnt_oh),
    .id_o    (gnt_id),
    .any_o   (gnt_any)
  );

  // Scan downward so the lowest free index is the one left standing.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!bitmap_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign raw_hit = cam_search_valid_i;
  assign eff_hit = cam_search_valid_i && bitmap_q[cam_search_index_i];

  always_comb begin
    int sel;
    state_d     = state_q;
    op_d        = op_q;
    key_d       = key_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    bitmap_d    = bitmap_q;
    occ_d       = occ_q;
    rsp_d       = rsp_q;
    req_ready_o = '0;
    sel         = int'(gnt_id);

    case (state_q)
      ST_IDLE: begin
        // Gated by reset so the accept pulse never appears while reset is held.
        if (gnt_any && reset) begin
          req_ready_o = gnt_oh;
          rr_ptr_d    = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
          op_d        = cam_decode_op(req_op_i[sel*2 +: 2]);
          key_d       = req_data_i[sel*DATA_WIDTH +: DATA_WIDTH];
          idx_d       = req_index_i[sel*IDX_W +: IDX_W];
          rsp_d       = '0;
          rsp_d.id    = CAM_MAX_ID_W'(gnt_id);
          if (op_d == CAM_DELETE) begin
            rsp_d.hit   = bitmap_q[idx_d];
            rsp_d.index = CAM_MAX_IDX_W'(idx_d);
            if (bitmap_q[idx_d]) begin
              bitmap_d[idx_d] = 1'b0;
              occ_d           = occ_q - 1'b1;
            end
            state_d = ST_RESP;
          end else begin
            state_d = ST_SEARCH;
          end
        end
      end

      ST_SEARCH: state_d = ST_EVAL;

      ST_EVAL: begin
        state_d = ST_RESP;
        if (op_q == CAM_INSERT) begin
          if (eff_hit) begin
            rsp_d.hit   = 1'b1;
            rsp_d.index = CAM_MAX_IDX_W'(cam_search_index_i);
          end else if (raw_hit) begin
            // Key still sits in the cam from before a delete: reclaim the slot.
            bitmap_d[cam_search_index_i] = 1'b1;
            occ_d                        = occ_q + 1'b1;
            rsp_d.index                  = CAM_MAX_IDX_W'(cam_search_index_i);
          end else if (free_found) begin
            idx_d   = free_idx;
            state_d = ST_WRITE;
          end else begin
            rsp_d.full = 1'b1;
          end
        end else begin
          rsp_d.hit   = eff_hit;
          rsp_d.index = eff_hit ? CAM_MAX_IDX_W'(cam_search_index_i) : '0;
        end
      end

      ST_WRITE: begin
        bitmap_d[idx_q] = 1'b1;
        occ_d           = occ_q + 1'b1;
        rsp_d.index     = CAM_MAX_IDX_W'(idx_q);
        state_d         = ST_RESP;
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= CAM_LOOKUP;
      key_q    <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      bitmap_q <= '0;
      occ_q    <= '0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      key_q    <= key_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      bitmap_q <= bitmap_d;
      occ_q    <= occ_d;
      rsp_q    <= rsp_d;
    end
  end

  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_id_o    = rsp_valid_o ? rsp_q.id[ID_W-1:0] : '0;
  assign rsp_hit_o   = rsp_valid_o & rsp_q.hit;
  assign rsp_full_o  = rsp_valid_o & rsp_q.full;
  assign rsp_index_o = rsp_valid_o ? rsp_q.index[IDX_W-1:0] : '0;
  assign occupancy_o = occ_q;

  assign cam_search_o      = (state_q == ST_SEARCH);
  assign cam_search_data_o = cam_search_o ? key_q : '0;
  assign cam_write_o       = (state_q == ST_WRITE);
  assign cam_write_index_o = cam_write_o ? idx_q : '0;
  assign cam_write_data_o  = cam_write_o ? key_q : '0;

  assign unused_rsp = ^{rsp_q.id, rsp_q.index};

endmodule

// File: tb/tb_cam_ctrl.sv
module tb_cam_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid_i = '0;
  logic [3:0]  req_op_i = '0;
  logic [63:0] req_data_i = '0;
  logic [7:0]  req_index_i = '0;
  logic [1:0]  req_ready_o;
  logic        rsp_valid_o;
  logic        rsp_id_o;
  logic        rsp_hit_o;
  logic        rsp_full_o;
  logic [3:0]  rsp_index_o;
  logic [4:0]  occupancy_o;
  logic        cam_search_o;
  logic [31:0] cam_search_data_o;
  logic        cam_search_valid_i = 1'b0;
  logic [3:0]  cam_search_index_i = '0;
  logic        cam_write_o;
  logic [3:0]  cam_write_index_o;
  logic [31:0] cam_write_data_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic overlap = 1'b0;

  localparam logic [1:0] OP_LK = 2'd0, OP_INS = 2'd1, OP_DEL = 2'd2;

  typedef struct {
    int          lat;
    logic        hit;
    logic        full;
    logic [3:0]  idx;
    logic        id;
    logic        wr;
    logic [3:0]  widx;
    logic [31:0] wdata;
    int          wcyc;
    logic [4:0]  occ;
  } res_t;

  cam_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid_i        (req_valid_i),
    .req_op_i           (req_op_i),
    .req_data_i         (req_data_i),
    .req_index_i        (req_index_i),
    .req_ready_o        (req_ready_o),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_id_o           (rsp_id_o),
    .rsp_hit_o          (rsp_hit_o),
    .rsp_full_o         (rsp_full_o),
    .rsp_index_o        (rsp_index_o),
    .occupancy_o        (occupancy_o),
    .cam_search_o       (cam_search_o),
    .cam_search_data_o  (cam_search_data_o),
    .cam_search_valid_i (cam_search_valid_i),
    .cam_search_index_i (cam_search_index_i),
    .cam_write_o        (cam_write_o),
    .cam_write_index_o  (cam_write_index_o),
    .cam_write_data_o   (cam_write_data_o)
  );

  always #5 clk = ~clk;

  // Behavioural cam: result registered one cycle after the search strobe.
  logic [31:0] cam_mem [16];
  logic [15:0] cam_used = '0;

  always @(posedge clk) begin
    if (cam_write_o) begin
      cam_mem[cam_write_index_o]  <= cam_write_data_o;
      cam_used[cam_write_index_o] <= 1'b1;
    end
    cam_search_valid_i <= 1'b0;
    cam_search_index_i <= '0;
    if (cam_search_o) begin
      for (int i = 15; i >= 0; i--) begin
        if (cam_used[i] && cam_mem[i] == cam_search_data_o) begin
          cam_search_valid_i <= 1'b1;
          cam_search_index_i <= 4'(i);
        end
      end
    end
  end

  always @(negedge clk) if (cam_search_o === 1'b1 && cam_write_o === 1'b1) overlap = 1'b1;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req_valid_i = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Issue one request; cycle 0 is the accept cycle, results sampled on negedges.
  task automatic run_op(input int r, input logic [1:0] op, input logic [31:0] key,
                        input logic [3:0] idx, output res_t res);
    int n;
    res = '{lat: -1, hit: 1'b0, full: 1'b0, idx: '0, id: 1'b0, wr: 1'b0,
            widx: '0, wdata: '0, wcyc: -1, occ: '0};
    @(negedge clk);
    req_valid_i = '0;
    req_valid_i[r] = 1'b1;
    req_op_i[r*2 +: 2] = op;
    req_data_i[r*32 +: 32] = key;
    req_index_i[r*4 +: 4] = idx;
    #1;
    n = 0;
    while (req_ready_o[r] !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (req_ready_o[r] !== 1'b1) begin
      req_valid_i = '0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid_i = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (cam_write_o === 1'b1) begin
        res.wr = 1'b1; res.widx = cam_write_index_o; res.wdata = cam_write_data_o; res.wcyc = c;
      end
      if (rsp_valid_o === 1'b1) begin
        res.lat = c; res.hit = rsp_hit_o; res.full = rsp_full_o;
        res.idx = rsp_index_o; res.id = rsp_id_o; res.occ = occupancy_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    req_valid_i = 2'b11;
    @(negedge clk);
    #1;
    n_checks++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", req_ready_o); end
    req_valid_i = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_o); end
    n_checks++; if (occupancy_o !== 5'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", occupancy_o); end
    n_checks++; if ({cam_search_o, cam_write_o} !== 2'b00) begin n_fail++; $display("FAIL reset_cam_strobes: got %b expected 00", {cam_search_o, cam_write_o}); end
    n_checks++; if ({rsp_hit_o, rsp_full_o, rsp_index_o} !== 6'd0) begin n_fail++; $display("FAIL reset_rsp_fields: got %h expected 0", {rsp_hit_o, rsp_full_o, rsp_index_o}); end
  endtask

  task automatic test_insert_lookup();
    res_t r;
    run_op(0, OP_INS, 32'hA5, 4'd0, r);
    n_checks++; if (r.wcyc !== 3 || r.widx !== 4'd0 || r.wdata !== 32'hA5) begin n_fail++; $display("FAIL ins_a5_write: got cyc %0d idx %0d data %h expected cyc 3 idx 0 data a5", r.wcyc, r.widx, r.wdata); end
    n_checks++; if (r.lat !== 4) begin n_fail++; $display("FAIL ins_a5_latency: got %0d expected 4", r.lat); end
    n_checks++; if ({r.hit, r.full, r.idx, r.id} !== 7'd0) begin n_fail++; $display("FAIL ins_a5_rsp: got hit %b full %b idx %0d id %0d expected all 0", r.hit, r.full, r.idx, r.id); end
    n_checks++; if (r.occ !== 5'd1) begin n_fail++; $display("FAIL ins_a5_occ: got %0d expected 1", r.occ); end

    run_op(1, OP_LK, 32'hA5, 4'd0, r);
    n_checks++; if (r.lat !== 3) begin n_fail++; $display("FAIL lk_a5_latency: got %0d expected 3", r.lat); end
    n_checks++; if (r.hit !== 1'b1 || r.idx !== 4'd0 || r.id !== 1'b1) begin n_fail++; $display("FAIL lk_a5_rsp: got hit %b idx %0d id %0d expected hit 1 idx 0 id 1", r.hit, r.idx, r.id); end

    run_op(0, OP_LK, 32'h77, 4'd0, r);
    n_checks++; if (r.lat !== 3 || r.hit !== 1'b0 || r.idx !== 4'd0) begin n_fail++; $display("FAIL lk_miss: got lat %0d hit %b idx %0d expected lat 3 hit 0 idx 0", r.lat, r.hit, r.idx); end

    run_op(1, 2'd3, 32'hA5, 4'd0, r);
    n_checks++; if (r.lat !== 3 || r.hit !== 1'b1) begin n_fail++; $display("FAIL op3_as_lookup: got lat %0d hit %b expected lat 3 hit 1", r.lat, r.hit); end

    run_op(0, OP_INS, 32'hA5, 4'd0, r);
    n_checks++; if (r.lat !== 3 || r.hit !== 1'b1 || r.wr !== 1'b0 || r.occ !== 5'd1) begin n_fail++; $display("FAIL ins_dup: got lat %0d hit %b wr %b occ %0d expected lat 3 hit 1 wr 0 occ 1", r.lat, r.hit, r.wr, r.occ); end
  endtask

  task automatic test_round_robin();
    int grants[$];
    int nrsp;
    do_reset();
    @(negedge clk);
    req_op_i = {OP_LK, OP_LK};
    req_data_i = {32'h1234, 32'h5678};
    req_valid_i = 2'b11;
    nrsp = 0;
    for (int c = 0; c < 40 && nrsp < 4; c++) begin
      #1;
      if (req_ready_o != 2'b00) begin
        n_checks++; if (req_ready_o !== 2'b01 && req_ready_o !== 2'b10) begin n_fail++; $display("FAIL rr_onehot: got %b expected one-hot", req_ready_o); end
        grants.push_back(req_ready_o[1] ? 1 : 0);
      end
      if (rsp_valid_o === 1'b1) begin
        n_checks++; if (nrsp >= grants.size() || int'(rsp_id_o) != grants[nrsp]) begin n_fail++; $display("FAIL rr_rsp_id: got %0d for response %0d", rsp_id_o, nrsp); end
        nrsp++;
        if (nrsp == 4) req_valid_i = '0;
      end
      @(negedge clk);
    end
    req_valid_i = '0;
    n_checks++; if (nrsp !== 4) begin n_fail++; $display("FAIL rr_rsp_count: got %0d expected 4", nrsp); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (k >= grants.size() || grants[k] != (k % 2)) begin n_fail++; $display("FAIL rr_grant_order: grant %0d got %0d expected %0d", k, (k < grants.size()) ? grants[k] : -1, k % 2); end
    end
  endtask

  task automatic test_full();
    res_t r;
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      run_op(i % 2, OP_INS, 32'h100 + i, 4'd0, r);
      if (r.lat != 4 || r.idx != 4'(i) || r.widx != 4'(i) || r.hit != 1'b0 || r.occ != 5'(i + 1)) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL fill_16: got %0d bad inserts expected 0", bad); end
    n_checks++; if (occupancy_o !== 5'd16) begin n_fail++; $display("FAIL fill_occ: got %0d expected 16", occupancy_o); end

    run_op(0, OP_INS, 32'h200, 4'd0, r);
    n_checks++; if (r.full !== 1'b1 || r.hit !== 1'b0 || r.idx !== 4'd0) begin n_fail++; $display("FAIL ins_full_rsp: got full %b hit %b idx %0d expected full 1 hit 0 idx 0", r.full, r.hit, r.idx); end
    n_checks++; if (r.lat !== 3 || r.wr !== 1'b0 || r.occ !== 5'd16) begin n_fail++; $display("FAIL ins_full_side: got lat %0d wr %b occ %0d expected lat 3 wr 0 occ 16", r.lat, r.wr, r.occ); end

    run_op(1, OP_LK, 32'h10F, 4'd0, r);
    n_checks++; if (r.hit !== 1'b1 || r.idx !== 4'd15) begin n_fail++; $display("FAIL lk_last_entry: got hit %b idx %0d expected hit 1 idx 15", r.hit, r.idx); end
  endtask

  task automatic test_stale_reuse();
    res_t r;
    do_reset();
    run_op(0, OP_INS, 32'h11, 4'd0, r);
    n_checks++; if (r.idx !== 4'd0 || r.wr !== 1'b1 || r.occ !== 5'd1) begin n_fail++; $display("FAIL ins_11: got idx %0d wr %b occ %0d expected idx 0 wr 1 occ 1", r.idx, r.wr, r.occ); end

    run_op(1, OP_DEL, 32'h0, 4'd0, r);
    n_checks++; if (r.lat !== 1 || r.hit !== 1'b1 || r.idx !== 4'd0 || r.occ !== 5'd0) begin n_fail++; $display("FAIL del_0: got lat %0d hit %b idx %0d occ %0d expected lat 1 hit 1 idx 0 occ 0", r.lat, r.hit, r.idx, r.occ); end

    run_op(0, OP_LK, 32'h11, 4'd0, r);
    n_checks++; if (r.hit !== 1'b0 || r.idx !== 4'd0) begin n_fail++; $display("FAIL lk_deleted: got hit %b idx %0d expected hit 0 idx 0", r.hit, r.idx); end

    run_op(1, OP_INS, 32'h11, 4'd0, r);
    n_checks++; if (r.lat !== 3 || r.hit !== 1'b0 || r.idx !== 4'd0) begin n_fail++; $display("FAIL stale_rsp: got lat %0d hit %b idx %0d expected lat 3 hit 0 idx 0", r.lat, r.hit, r.idx); end
    n_checks++; if (r.wr !== 1'b0 || r.occ !== 5'd1) begin n_fail++; $display("FAIL stale_side: got wr %b occ %0d expected wr 0 occ 1", r.wr, r.occ); end
  endtask

  task automatic test_delete_free();
    res_t r;
    run_op(0, OP_DEL, 32'h0, 4'd5, r);
    n_checks++; if (r.lat !== 1 || r.hit !== 1'b0 || r.idx !== 4'd5) begin n_fail++; $display("FAIL del_free: got lat %0d hit %b idx %0d expected lat 1 hit 0 idx 5", r.lat, r.hit, r.idx); end
    n_checks++; if (r.occ !== 5'd1) begin n_fail++; $display("FAIL del_free_occ: got %0d expected 1", r.occ); end
  endtask

  task automatic test_reset_in_eval();
    res_t r;
    int seen_rsp, seen_wr;
    do_reset();
    @(negedge clk);
    req_valid_i = 2'b01;
    req_op_i[1:0] = OP_INS;
    req_data_i[31:0] = 32'h33;
    #1;
    n_checks++; if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL abort_accept: got %b expected 01", req_ready_o); end
    @(posedge clk);
    #1;
    req_valid_i = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen_rsp = 0;
    seen_wr = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid_o === 1'b1) seen_rsp++;
      if (cam_write_o === 1'b1) seen_wr++;
      @(negedge clk);
    end
    n_checks++; if (seen_rsp !== 0 || seen_wr !== 0) begin n_fail++; $display("FAIL abort_quiet: got rsp %0d write %0d expected 0 0", seen_rsp, seen_wr); end
    n_checks++; if (occupancy_o !== 5'd0) begin n_fail++; $display("FAIL abort_occ: got %0d expected 0", occupancy_o); end

    run_op(1, OP_LK, 32'h11, 4'd0, r);
    n_checks++; if (r.lat !== 3 || r.hit !== 1'b0) begin n_fail++; $display("FAIL abort_bitmap: got lat %0d hit %b expected lat 3 hit 0", r.lat, r.hit); end

    run_op(0, OP_INS, 32'h44, 4'd0, r);
    n_checks++; if (r.lat !== 4 || r.idx !== 4'd0 || r.wdata !== 32'h44 || r.occ !== 5'd1) begin n_fail++; $display("FAIL abort_next: got lat %0d idx %0d data %h occ %0d expected lat 4 idx 0 data 44 occ 1", r.lat, r.idx, r.wdata, r.occ); end
  endtask

  task automatic test_exclusive_strobes();
    n_checks++; if (overlap !== 1'b0) begin n_fail++; $display("FAIL search_write_overlap: got %b expected 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_insert_lookup();
    test_round_robin();
    test_full();
    test_stale_reuse();
    test_delete_free();
    test_reset_in_eval();
    test_exclusive_strobes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
